// File: rtl/pkt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pkt_rr_arbiter
// Purpose  : Packet-level round-robin arbiter. Picks one requester and keeps
//            its grant locked until that requester transfers its
//            end-of-packet word. Then the search resumes after the last
//            winner.
// Ports    : clk_i        - clock, rising-edge active
//            rst_n_i      - asynchronous active-low reset
//            req_i        - per-requester word valid
//            eop_i        - per-requester last-word-of-packet marker
//            ready_i      - downstream accepts the muxed word
//            grant_o      - registered one-hot (or zero) mux select
//            grant_idx_o  - binary index of grant_o (0 when idle)
//            valid_o      - muxed word valid (|(grant_o & req_i))
//            ack_o        - pop strobe to the granted requester
// Config   : `define PKT_RR_ARB_BACK_TO_BACK_EN makes the end-of-packet
//            cycle hand the grant straight to the next requester. There is
//            no idle bubble.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_rr_arbiter #(
  parameter int INPUT_CNT = 2,
  parameter int IDX_W     = (INPUT_CNT > 1) ? $clog2(INPUT_CNT) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [INPUT_CNT-1:0] req_i,
  input  logic [INPUT_CNT-1:0] eop_i,
  input  logic                 ready_i,
  output logic [INPUT_CNT-1:0] grant_o,
  output logic [IDX_W-1:0]     grant_idx_o,
  output logic                 valid_o,
  output logic [INPUT_CNT-1:0] ack_o
);

  localparam logic [0:0]       c_ST_IDLE   = 1'b0;
  localparam logic [0:0]       c_ST_LOCKED = 1'b1;
  // After reset the last winner is the top index. Input 0 is searched first.
  localparam logic [IDX_W-1:0] c_LAST_RST  = IDX_W'(INPUT_CNT - 1);
  localparam logic [IDX_W:0]   c_CNT_EXT   = (IDX_W+1)'(INPUT_CNT);

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [INPUT_CNT-1:0] r_grant;
  logic [INPUT_CNT-1:0] w_grant_nxt;
  logic [IDX_W-1:0]     r_grant_idx;
  logic [IDX_W-1:0]     w_grant_idx_nxt;
  logic [IDX_W-1:0]     r_last;
  logic [IDX_W-1:0]     w_last_nxt;

  logic [INPUT_CNT-1:0] w_cand;
  logic [INPUT_CNT-1:0] w_win_oh;
  logic [IDX_W-1:0]     w_win_idx;
  logic [IDX_W:0]       w_sum;
  logic                 w_found;
  logic [INPUT_CNT-1:0] w_ack;
  logic                 w_eop_xfer;

  // --------------------------------------------------------------------------
  // Round-robin search: the first candidate at r_last+1, r_last+2, ... mod N.
  // The current holder is masked out. This changes nothing in IDLE, where
  // r_grant is zero. During a back-to-back hand-over it keeps the finishing
  // requester from winning again while any other requester is waiting.
  // The loop runs from farthest to nearest, so the nearest hit is written
  // last and wins.
  // --------------------------------------------------------------------------
  always_comb begin : p_search
    w_cand    = req_i & ~r_grant;
    w_found   = 1'b0;
    w_win_idx = '0;
    w_sum     = '0;
    for (int k = INPUT_CNT; k >= 1; k--) begin
      w_sum = {1'b0, r_last} + (IDX_W+1)'(k);
      if (w_sum >= c_CNT_EXT) begin
        w_sum = w_sum - c_CNT_EXT;
      end
      if (w_cand[w_sum[IDX_W-1:0]]) begin
        w_found   = 1'b1;
        w_win_idx = w_sum[IDX_W-1:0];
      end
    end
    w_win_oh = '0;
    if (w_found) begin
      w_win_oh[w_win_idx] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= c_ST_IDLE;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_last      <= c_LAST_RST;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_last      <= w_last_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin : p_next
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_grant_idx_nxt = r_grant_idx;
    w_last_nxt      = r_last;
    case (r_state)
      c_ST_IDLE: begin
        if (w_found) begin
          w_state_nxt     = c_ST_LOCKED;
          w_grant_nxt     = w_win_oh;
          w_grant_idx_nxt = w_win_idx;
          w_last_nxt      = w_win_idx;
        end
      end
      c_ST_LOCKED: begin
        // The grant is held through stalls, req drops and competing requests.
        // Only an accepted end-of-packet word releases it.
        if (w_eop_xfer) begin
`ifdef PKT_RR_ARB_BACK_TO_BACK_EN
          // r_last already equals the current winner, so the search above
          // yields the successor in this cycle.
          if (w_found) begin
            w_grant_nxt     = w_win_oh;
            w_grant_idx_nxt = w_win_idx;
            w_last_nxt      = w_win_idx;
          end else begin
            w_state_nxt     = c_ST_IDLE;
            w_grant_nxt     = '0;
            w_grant_idx_nxt = '0;
          end
`else
          w_state_nxt     = c_ST_IDLE;
          w_grant_nxt     = '0;
          w_grant_idx_nxt = '0;
`endif
        end
      end
      default: begin
        w_state_nxt     = c_ST_IDLE;
        w_grant_nxt     = '0;
        w_grant_idx_nxt = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic. Masking with r_grant makes non-granted req/eop bits inert.
  // --------------------------------------------------------------------------
  always_comb begin : p_out
    w_ack      = r_grant & req_i & {INPUT_CNT{ready_i}};
    w_eop_xfer = |(w_ack & eop_i);
  end

  assign grant_o     = r_grant;
  assign grant_idx_o = r_grant_idx;
  assign valid_o     = |(r_grant & req_i);
  assign ack_o       = w_ack;

endmodule
`default_nettype wire

// File: tb/tb_pkt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_rr_arbiter
// Purpose  : Self-checking bench for pkt_rr_arbiter. It drives a 4-input
//            instance and a 1-input instance. The expected outputs come from
//            a packet-level round-robin reference model. It is mode-aware
//            through PKT_RR_ARB_BACK_TO_BACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req4, eop4, grant4, ack4;
  logic       rdy4, valid4;
  logic [1:0] idx4;
  logic [0:0] req1, eop1, grant1, ack1, idx1;
  logic       rdy1, valid1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: granted index (-1 = none) and last winner, per unit.
  int m_gnt[2];
  int m_last[2];
  int m_n[2];

  always #5 clk = ~clk;

  pkt_rr_arbiter #(.INPUT_CNT(4)) u_dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req4), .eop_i(eop4), .ready_i(rdy4),
    .grant_o(grant4), .grant_idx_o(idx4), .valid_o(valid4), .ack_o(ack4)
  );

  pkt_rr_arbiter #(.INPUT_CNT(1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req1), .eop_i(eop1), .ready_i(rdy1),
    .grant_o(grant1), .grant_idx_o(idx1), .valid_o(valid1), .ack_o(ack1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // First requester after 'last' in circular order, skipping 'excl'.
  function automatic int rr_pick(input logic [31:0] r, input int last, input int n, input int excl);
    for (int k = 1; k <= n; k++) begin
      int i;
      i = (last + k) % n;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_gnt[u]  = -1;
      m_last[u] = m_n[u] - 1;
    end
  endtask

  // Advance one clock edge of the model, given the inputs seen at that edge.
  task automatic model_tick(input int u, input logic [31:0] r, input logic [31:0] e, input logic rdy);
    int g;
    int p;
    g = m_gnt[u];
    if (g < 0) begin
      p = rr_pick(r, m_last[u], m_n[u], -1);
      if (p >= 0) begin
        m_gnt[u]  = p;
        m_last[u] = p;
      end
    end else if (r[g] && rdy && e[g]) begin
`ifdef PKT_RR_ARB_BACK_TO_BACK_EN
      p = rr_pick(r, g, m_n[u], g);
      m_gnt[u] = p;
      if (p >= 0) m_last[u] = p;
`else
      m_gnt[u] = -1;
`endif
    end
  endtask

  task automatic check_unit(input string nm, input int u, input logic [31:0] r, input logic rdy,
                            input logic [31:0] g_obs, input logic [31:0] i_obs,
                            input logic [31:0] v_obs, input logic [31:0] a_obs);
    logic [31:0] eg, ea, ei;
    logic        ev;
    int          g;
    g  = m_gnt[u];
    eg = '0; ea = '0; ei = '0; ev = 1'b0;
    if (g >= 0) begin
      eg = 32'd1 << g;
      ei = 32'(g);
      ev = r[g];
      if (r[g] && rdy) ea = eg;
    end
    chk({nm, ".grant"},   g_obs, eg);
    chk({nm, ".idx"},     i_obs, ei);
    chk({nm, ".valid"},   v_obs, 32'(ev));
    chk({nm, ".ack"},     a_obs, ea);
    chk({nm, ".onehot0"}, 32'($onehot0(g_obs)), 32'd1);
  endtask

  // One clock cycle: drive at the falling edge, check 1 ns later, then let
  // the model consume the same inputs at the next rising edge.
  task automatic step(input logic [3:0] r4, input logic [3:0] e4, input logic rd4,
                      input logic r1, input logic e1, input logic rd1);
    @(negedge clk);
    req4 = r4; eop4 = e4; rdy4 = rd4;
    req1 = r1; eop1 = e1; rdy1 = rd1;
    #1;
    check_unit("u4", 0, 32'(r4), rd4, 32'(grant4), 32'(idx4), 32'(valid4), 32'(ack4));
    check_unit("u1", 1, 32'(r1), rd1, 32'(grant1), 32'(idx1), 32'(valid1), 32'(ack1));
    model_tick(0, 32'(r4), 32'(e4), rd4);
    model_tick(1, 32'(r1), 32'(e1), rd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req4 = 4'b1111; eop4 = 4'b1111; rdy4 = 1'b1;
    req1 = 1'b1;    eop1 = 1'b1;    rdy1 = 1'b1;
    model_reset();
    #1;
    chk("rst.grant4", 32'(grant4), 32'd0);
    chk("rst.idx4",   32'(idx4),   32'd0);
    chk("rst.valid4", 32'(valid4), 32'd0);
    chk("rst.ack4",   32'(ack4),   32'd0);
    chk("rst.grant1", 32'(grant1), 32'd0);
    repeat (2) @(negedge clk);
    req4 = '0; eop4 = '0; rdy4 = 1'b0;
    req1 = '0; eop1 = '0; rdy1 = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          order_q[$];
    int          gap_q[$];
    int          exp_order[5];
    int          exp_gap;
    int          gap, words, acks, found;
    logic        dropped, rdy;
    logic [3:0]  prev, r, e;

    m_n[0] = 4;
    m_n[1] = 1;
    rst_n = 1'b0;
    req4 = '0; eop4 = '0; rdy4 = 1'b0;
    req1 = '0; eop1 = '0; rdy1 = 1'b0;
    model_reset();
    exp_order = '{0, 1, 2, 3, 0};
`ifdef PKT_RR_ARB_BACK_TO_BACK_EN
    exp_gap = 0;
`else
    exp_gap = 1;
`endif

    // Round-robin order with all four inputs requesting single-word packets.
    do_reset();
    gap = 0;
    prev = '0;
    for (int c = 0; c < 12; c++) begin
      step(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
      if (grant4 != 4'b0000 && grant4 != prev) begin
        order_q.push_back(int'(idx4));
        gap_q.push_back(gap);
        gap = 0;
      end
      if (grant4 == 4'b0000) gap++;
      prev = grant4;
    end
    chk("rr.count", 32'(order_q.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < order_q.size()) chk("rr.order", 32'(order_q[i]), 32'(exp_order[i]));
      if (i >= 1 && i < gap_q.size()) chk("rr.gap", 32'(gap_q[i]), 32'(exp_gap));
    end

    // Five-word packet on input 1: req drop, toggling ready, competing req 3.
    do_reset();
    step(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    words = 0; acks = 0; dropped = 1'b0;
    for (int c = 0; c < 40 && words < 5; c++) begin
      rdy = (c % 2 == 1);
      r = 4'b1010;
      if (words == 2 && !dropped) begin
        r = 4'b1000;
        dropped = 1'b1;
      end
      e = (words == 4) ? 4'b0010 : 4'b0000;
      step(r, e, rdy, 1'b0, 1'b0, 1'b0);
      chk("pkt.hold", 32'(grant4), 32'h2);
      if (ack4[1]) acks++;
      if (r[1] && rdy) words++;
    end
    chk("pkt.acks", 32'(acks), 32'd5);
    found = 0;
    for (int k = 0; k < 3 && found == 0; k++) begin
      step(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      if (grant4 != 4'b0000) found = 1;
    end
    chk("pkt.next", 32'(grant4), 32'h8);

    // EOP held off by ready_i low.
    step(4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
    found = 0;
    for (int k = 0; k < 3 && found == 0; k++) begin
      step(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      if (grant4 != 4'b0000) found = 1;
    end
    chk("eop.setup", 32'(grant4), 32'h2);
    repeat (3) begin
      step(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("eop.hold",  32'(grant4), 32'h2);
      chk("eop.noack", 32'(ack4),   32'h0);
    end
    step(4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("eop.ack", 32'(ack4), 32'h2);
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("eop.released", 32'(grant4), 32'h0);

    // Reset during word 2 of a packet from input 2.
    do_reset();
    step(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    req4 = 4'b0100; eop4 = 4'b0000; rdy4 = 1'b1;
    #1;
    chk("arst.pre", 32'(grant4), 32'h4);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.grant", 32'(grant4), 32'h0);
    chk("arst.ack",   32'(ack4),   32'h0);
    chk("arst.idx",   32'(idx4),   32'h0);
    model_reset();
    @(negedge clk);
    req4 = '0; eop4 = '0; rdy4 = 1'b0;
    rst_n = 1'b1;
    step(4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("arst.first", 32'(grant4), 32'h2);

    // Single-input instance: three single-word packets.
    acks = 0;
    for (int c = 0; c < 12 && acks < 3; c++) begin
      step(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
      if (grant1 != 1'b0) chk("n1.grant", 32'(grant1), 32'd1);
      chk("n1.idx", 32'(idx1), 32'd0);
      if (ack1[0]) acks++;
    end
    chk("n1.acks", 32'(acks), 32'd3);

    // Random traffic against the model, with one reset in the middle.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset();
      r   = 4'($urandom);
      e   = 4'($urandom) & 4'($urandom);
      rdy = ($urandom_range(3) != 0);
      step(r, e, rdy, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
